// File: rtl/mandelbrot_pkg.sv
// Shared types and default geometry for the Mandelbrot pixel pipeline.
package mandelbrot_pkg;

    localparam int DEFAULT_H_RES  = 640;
    localparam int DEFAULT_V_RES  = 480;
    localparam int DEFAULT_ADDR_W = 19;
    localparam int ITER_W         = 6;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_ISSUE,
        SEQ_WAIT_RESULT,
        SEQ_RELEASE,
        SEQ_FRAME_END
    } seq_state_e;

    // One finished pixel as it travels to the framebuffer writer.
    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0] addr;
        logic [ITER_W-1:0]         iter;
        logic                      in_set;
    } result_t;

    localparam int RESULT_W = $bits(result_t);

endpackage

// File: rtl/mandelbrot_result_fifo.sv
// Synchronous result FIFO with flush; the head entry is presented directly.
module mandelbrot_result_fifo
    import mandelbrot_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = RESULT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        data_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W:0]    count_q;
    logic              do_push;
    logic              do_pop;

    // Full is judged on the registered count, so a push offered while full is refused even if a pop frees a slot.
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mandelbrot_pixel_sequencer.sv
// Raster-order scheduler feeding one pixel at a time to mandelbrot_engine
// and queueing its results for the framebuffer writer.
module mandelbrot_pixel_sequencer
    import mandelbrot_pkg::*;
#(
    parameter int H_RES      = DEFAULT_H_RES,
    parameter int V_RES      = DEFAULT_V_RES,
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                continuous_i,
    input  logic                abort_i,
    input  logic signed [15:0]  center_x_in_i,
    input  logic signed [15:0]  center_y_in_i,
    input  logic [7:0]          zoom_in_i,
    input  logic [5:0]          max_iter_in_i,
    output logic [9:0]          eng_pixel_x_o,
    output logic [9:0]          eng_pixel_y_o,
    output logic                eng_pixel_valid_o,
    output logic                eng_enable_o,
    output logic signed [15:0]  eng_center_x_o,
    output logic signed [15:0]  eng_center_y_o,
    output logic [7:0]          eng_zoom_o,
    output logic [5:0]          eng_max_iter_o,
    input  logic [5:0]          eng_iteration_count_i,
    input  logic                eng_result_valid_i,
    input  logic                eng_busy_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [ADDR_W-1:0]   out_addr_o,
    output logic [5:0]          out_iter_o,
    output logic                out_in_set_o,
    output logic                frame_busy_o,
    output logic                frame_done_o
);

    localparam int         DATA_W = ADDR_W + ITER_W + 1;
    localparam int         CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [9:0] X_LAST = 10'(H_RES - 1);
    localparam logic [9:0] Y_LAST = 10'(V_RES - 1);

    seq_state_e         state_q, state_d;
    logic [9:0]         x_q, x_d;
    logic [9:0]         y_q, y_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               pix_valid_q, pix_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic signed [15:0] cx_q, cx_d;
    logic signed [15:0] cy_q, cy_d;
    logic [7:0]         zoom_q, zoom_d;
    logic [5:0]         max_iter_q, max_iter_d;

    logic               latch_frame;
    logic               in_set;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [DATA_W-1:0]  fifo_wdata;
    logic [DATA_W-1:0]  fifo_head;

    assign in_set     = (eng_iteration_count_i >= max_iter_q);
    assign fifo_wdata = {addr_q, eng_iteration_count_i, in_set};
    assign fifo_pop   = out_valid_o && out_ready_i;

    mandelbrot_result_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_result_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (abort_i),
        .push_i  (fifo_push),
        .data_i  (fifo_wdata),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEQ_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            addr_q      <= '0;
            pix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cx_q        <= '0;
            cy_q        <= '0;
            zoom_q      <= '0;
            max_iter_q  <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            addr_q      <= addr_d;
            pix_valid_q <= pix_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            zoom_q      <= zoom_d;
            max_iter_q  <= max_iter_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        addr_d      = addr_q;
        pix_valid_d = pix_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cx_d        = cx_q;
        cy_d        = cy_q;
        zoom_d      = zoom_q;
        max_iter_d  = max_iter_q;
        fifo_push   = 1'b0;
        latch_frame = 1'b0;

        case (state_q)
            SEQ_IDLE: begin
                if (start_i) begin
                    latch_frame = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = SEQ_ISSUE;
                end
            end
            SEQ_ISSUE: begin
                if (!eng_busy_i && !eng_result_valid_i) begin
                    pix_valid_d = 1'b1;
                    state_d     = SEQ_WAIT_RESULT;
                end
            end
            SEQ_WAIT_RESULT: begin
                if (eng_result_valid_i && !fifo_full) begin
                    fifo_push   = 1'b1;
                    pix_valid_d = 1'b0;
                    state_d     = SEQ_RELEASE;
                end
            end
            // The engine keeps result_valid up for a cycle after the request drops; wait it out.
            SEQ_RELEASE: begin
                if (!eng_result_valid_i && !eng_busy_i) begin
                    if (x_q == X_LAST && y_q == Y_LAST) begin
                        state_d = SEQ_FRAME_END;
                    end else begin
                        if (x_q == X_LAST) begin
                            x_d = '0;
                            y_d = y_q + 10'd1;
                        end else begin
                            x_d = x_q + 10'd1;
                        end
                        addr_d      = addr_q + 1'b1;
                        pix_valid_d = 1'b1;
                        state_d     = SEQ_WAIT_RESULT;
                    end
                end
            end
            SEQ_FRAME_END: begin
                if (fifo_count == '0) begin
                    done_d = 1'b1;
                    if (continuous_i) begin
                        latch_frame = 1'b1;
                        state_d     = SEQ_ISSUE;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = SEQ_IDLE;
                    end
                end
            end
            default: state_d = SEQ_IDLE;
        endcase

        if (latch_frame) begin
            x_d        = '0;
            y_d        = '0;
            addr_d     = '0;
            cx_d       = center_x_in_i;
            cy_d       = center_y_in_i;
            zoom_d     = zoom_in_i;
            max_iter_d = max_iter_in_i;
        end

        if (abort_i) begin
            state_d     = SEQ_IDLE;
            pix_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            fifo_push   = 1'b0;
        end
    end

    assign eng_pixel_x_o     = x_q;
    assign eng_pixel_y_o     = y_q;
    assign eng_pixel_valid_o = pix_valid_q;
    assign eng_enable_o      = busy_q;
    assign eng_center_x_o    = cx_q;
    assign eng_center_y_o    = cy_q;
    assign eng_zoom_o        = zoom_q;
    assign eng_max_iter_o    = max_iter_q;
    assign frame_busy_o      = busy_q;
    assign frame_done_o      = done_q;
    assign out_valid_o       = !fifo_empty;
    assign {out_addr_o, out_iter_o, out_in_set_o} = fifo_head;

endmodule

// File: tb/tb_mandelbrot_pixel_sequencer.sv
// Randomized bench for mandelbrot_pixel_sequencer with a reactive engine model
// and a raster-order scoreboard on the result stream.
module tb_mandelbrot_pixel_sequencer;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 4;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic               startI = 0, continuousI = 0, abortI = 0, outReady = 1;
    logic signed [15:0] cxIn = 0, cyIn = 0;
    logic [7:0]         zoomIn = 0;
    logic [5:0]         maxIterIn = 0;
    logic [5:0]         engIter = 0;
    logic               engRv = 0, engBusy = 0;

    logic [9:0]         engPixelX, engPixelY;
    logic               engPixelValid, engEnable;
    logic signed [15:0] engCx, engCy;
    logic [7:0]         engZoom;
    logic [5:0]         engMaxIter;
    logic               outValid, outInSet, frameBusy, frameDone;
    logic [AW-1:0]      outAddr;
    logic [5:0]         outIter;

    mandelbrot_pixel_sequencer #(
        .H_RES(H), .V_RES(V), .ADDR_W(AW), .FIFO_DEPTH(FD)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .start_i               (startI),
        .continuous_i          (continuousI),
        .abort_i               (abortI),
        .center_x_in_i         (cxIn),
        .center_y_in_i         (cyIn),
        .zoom_in_i             (zoomIn),
        .max_iter_in_i         (maxIterIn),
        .eng_pixel_x_o         (engPixelX),
        .eng_pixel_y_o         (engPixelY),
        .eng_pixel_valid_o     (engPixelValid),
        .eng_enable_o          (engEnable),
        .eng_center_x_o        (engCx),
        .eng_center_y_o        (engCy),
        .eng_zoom_o            (engZoom),
        .eng_max_iter_o        (engMaxIter),
        .eng_iteration_count_i (engIter),
        .eng_result_valid_i    (engRv),
        .eng_busy_i            (engBusy),
        .out_valid_o           (outValid),
        .out_ready_i           (outReady),
        .out_addr_o            (outAddr),
        .out_iter_o            (outIter),
        .out_in_set_o          (outInSet),
        .frame_busy_o          (frameBusy),
        .frame_done_o          (frameDone)
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Engine behaviour: 0 -> x+y, 1 -> always 63, 2 -> always 5, 3 -> salted hash of the coordinate.
    int iterMode = 0;
    int salt     = 0;

    function automatic logic [5:0] engineIter(input int x, input int y);
        case (iterMode)
            0:       return 6'(x + y);
            1:       return 6'd63;
            2:       return 6'd5;
            default: return 6'((x * 7 + y * 13 + salt) % 64);
        endcase
    endfunction

    int eState = 0, eCnt = 0, ex = 0, ey = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            eState  = 0;
            engBusy = 1'b0;
            engRv   = 1'b0;
        end else begin
            case (eState)
                0: begin
                    engRv   = 1'b0;
                    engBusy = 1'b0;
                    if (engPixelValid) begin
                        ex      = int'(engPixelX);
                        ey      = int'(engPixelY);
                        eCnt    = $urandom_range(1, 4);
                        engBusy = 1'b1;
                        eState  = 1;
                    end
                end
                1: begin
                    eCnt--;
                    if (eCnt == 0) begin
                        engBusy = 1'b0;
                        engRv   = 1'b1;
                        engIter = engineIter(ex, ey);
                        eState  = 2;
                    end
                end
                2: if (!engPixelValid) eState = 3;
                default: begin
                    engRv  = 1'b0;
                    eState = 0;
                end
            endcase
        end
    end

    // Scoreboard: results must come out in raster order with the frame's latched parameters.
    int                 expAddr = 0, popCount = 0, doneCount = 0;
    logic signed [15:0] expCx = 0, expCy = 0, snapCx = 0, snapCy = 0;
    logic [7:0]         expZoom = 0, snapZoom = 0;
    logic [5:0]         expMaxIter = 0, snapMaxIter = 0;
    logic               snapCont = 0, prevBusy = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prevBusy = 1'b0;
        end else begin
            if (outValid && outReady) begin
                logic [5:0] expIter;
                expIter = engineIter(expAddr % H, expAddr / H);
                checkOutput("outAddr", 32'(outAddr), expAddr);
                checkOutput("outIter", 32'(outIter), 32'(expIter));
                checkOutput("outInSet", 32'(outInSet), 32'(expIter >= expMaxIter));
                expAddr++;
                popCount++;
            end
            if (frameDone) begin
                doneCount++;
                checkOutput("pixelsAtDone", expAddr, H * V);
                checkOutput("busyAtDone", 32'(frameBusy), 32'(snapCont));
            end
            if ((!prevBusy && frameBusy) || (frameDone && frameBusy)) begin
                expCx      = snapCx;
                expCy      = snapCy;
                expZoom    = snapZoom;
                expMaxIter = snapMaxIter;
                expAddr    = 0;
            end
            if (frameBusy) begin
                checkOutput("engCenterX", 32'(engCx), 32'(expCx));
                checkOutput("engCenterY", 32'(engCy), 32'(expCy));
                checkOutput("engZoom", 32'(engZoom), 32'(expZoom));
                checkOutput("engMaxIter", 32'(engMaxIter), 32'(expMaxIter));
            end
            prevBusy    = frameBusy;
            snapCx      = cxIn;
            snapCy      = cyIn;
            snapZoom    = zoomIn;
            snapMaxIter = maxIterIn;
            snapCont    = continuousI;
        end
    end

    logic randReady = 0;

    task automatic applyStimulus(input logic signed [15:0] cx, input logic signed [15:0] cy,
                                 input logic [7:0] zoom, input logic [5:0] maxIter, input logic cont);
        @(posedge clk); #1;
        cxIn        = cx;
        cyIn        = cy;
        zoomIn      = zoom;
        maxIterIn   = maxIter;
        continuousI = cont;
        startI      = 1'b1;
        @(posedge clk); #1;
        startI      = 1'b0;
        checkOutput("busyAfterStart", 32'(frameBusy), 1);
        checkOutput("enableAfterStart", 32'(engEnable), 1);
    endtask

    task automatic waitFrames(input int n, input int budget);
        int target;
        int c;
        target = doneCount + n;
        c = 0;
        while (doneCount < target && c < budget) begin
            @(posedge clk); #1;
            if (randReady) outReady = 1'($urandom_range(0, 1));
            c++;
        end
        checkOutput("frameDoneCount", doneCount, target);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int p0, c, doneBefore;

        rst_n = 1'b0;
        #12;
        checkOutput("rstPixelValid", 32'(engPixelValid), 0);
        checkOutput("rstEnable", 32'(engEnable), 0);
        checkOutput("rstCenterX", 32'(engCx), 0);
        checkOutput("rstMaxIter", 32'(engMaxIter), 0);
        checkOutput("rstOutValid", 32'(outValid), 0);
        checkOutput("rstOutAddr", 32'(outAddr), 0);
        checkOutput("rstOutIter", 32'(outIter), 0);
        checkOutput("rstFrameBusy", 32'(frameBusy), 0);
        checkOutput("rstFrameDone", 32'(frameDone), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("[TB] basic frame, iter = x+y");
        iterMode = 0;
        applyStimulus(16'sh1000, -16'sh0800, 8'd3, 6'd20, 1'b0);
        waitFrames(1, 600);
        checkOutput("donePulseLow", 32'(frameDone), 0);
        checkOutput("busyLowAfterFrame", 32'(frameBusy), 0);

        $display("[TB] in-set boundaries");
        iterMode = 1;
        applyStimulus(16'sh0100, 16'sh0200, 8'd1, 6'd20, 1'b0);
        waitFrames(1, 600);
        iterMode = 2;
        applyStimulus(16'sh0100, 16'sh0200, 8'd1, 6'd20, 1'b0);
        waitFrames(1, 600);
        iterMode = 3;
        salt = 1;
        applyStimulus(16'sh0300, 16'sh0400, 8'd9, 6'd63, 1'b0);
        waitFrames(1, 600);

        $display("[TB] backpressure");
        iterMode = 0;
        outReady = 1'b0;
        p0 = popCount;
        applyStimulus(16'sh0042, 16'sh0024, 8'd5, 6'd4, 1'b0);
        repeat (50) @(posedge clk);
        #1;
        checkOutput("stallOutValid", 32'(outValid), 1);
        checkOutput("stallPixelValid", 32'(engPixelValid), 1);
        checkOutput("stallPixelX", 32'(engPixelX), 0);
        checkOutput("stallPixelY", 32'(engPixelY), 1);
        checkOutput("stallHeadAddr", 32'(outAddr), 0);
        checkOutput("stallNoPops", popCount, p0);
        outReady = 1'b1;
        waitFrames(1, 600);
        checkOutput("popsAfterStall", popCount, p0 + H * V);

        $display("[TB] continuous with mid-frame parameter change");
        iterMode = 3;
        salt = 17;
        applyStimulus(16'sh0111, 16'sh0222, 8'd7, 6'd30, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        cxIn   = 16'sh0555;
        cyIn   = -16'sh0666;
        startI = 1'b1;
        @(posedge clk); #1;
        startI = 1'b0;
        checkOutput("centerXHeld", 32'(engCx), 32'(16'sh0111));
        waitFrames(1, 600);
        checkOutput("centerXRelatched", 32'(engCx), 32'(16'sh0555));
        checkOutput("busyContinuous", 32'(frameBusy), 1);
        continuousI = 1'b0;
        waitFrames(1, 600);
        checkOutput("busyAfterContinuous", 32'(frameBusy), 0);

        $display("[TB] randomized frames");
        randReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            salt = $urandom_range(0, 63);
            applyStimulus(16'($urandom), 16'($urandom), 8'($urandom), 6'($urandom_range(1, 63)), 1'b0);
            waitFrames(1, 1500);
        end
        randReady = 1'b0;
        outReady  = 1'b1;

        $display("[TB] abort during WAIT_RESULT");
        iterMode = 0;
        p0 = popCount;
        applyStimulus(16'sh0010, 16'sh0020, 8'd2, 6'd10, 1'b0);
        c = 0;
        while (!(engPixelValid && popCount >= p0 + 2) && c < 400) begin
            @(posedge clk); #1;
            c++;
        end
        checkOutput("reachedWaitResult", 32'(engPixelValid), 1);
        doneBefore = doneCount;
        abortI = 1'b1;
        @(posedge clk); #1;
        abortI = 1'b0;
        checkOutput("abortPixelValid", 32'(engPixelValid), 0);
        checkOutput("abortOutValid", 32'(outValid), 0);
        checkOutput("abortFrameBusy", 32'(frameBusy), 0);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("abortNoDone", doneCount, doneBefore);
        p0 = popCount;
        applyStimulus(16'sh0030, 16'sh0040, 8'd4, 6'd3, 1'b0);
        waitFrames(1, 600);
        checkOutput("fullFrameAfterAbort", popCount, p0 + H * V);

        $display("[TB] asynchronous reset mid-frame");
        applyStimulus(16'sh0777, 16'sh0888, 8'd6, 6'd12, 1'b0);
        repeat (15) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncPixelValid", 32'(engPixelValid), 0);
        checkOutput("asyncFrameBusy", 32'(frameBusy), 0);
        checkOutput("asyncEnable", 32'(engEnable), 0);
        checkOutput("asyncOutValid", 32'(outValid), 0);
        checkOutput("asyncOutAddr", 32'(outAddr), 0);
        checkOutput("asyncCenterX", 32'(engCx), 0);
        checkOutput("asyncZoom", 32'(engZoom), 0);
        checkOutput("asyncPixelX", 32'(engPixelX), 0);
        #10;
        @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus(16'sh0123, 16'sh0321, 8'd8, 6'd2, 1'b0);
        waitFrames(1, 600);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
